// File: rtl/noc_funnel_arb.sv
// noc_funnel_arb: multi-channel NOC message funnel.
// Round-robin arbitration across CHANNELS single-entry holding registers. Each
// granted message is serialised onto one WIDTH-bit stream. The stream carries an
// optional header beat and a last flag on the final beat.
//
// Ports:
//   CLK, nRST           clock, synchronous active-low reset
//   in_enq__ENA[i]      enqueue strobe for channel i (only while in_enq__RDY[i])
//   in_enq_v            CHANNELS x DATA_WIDTH payloads, channel i at slice i
//   in_enq_length       CHANNELS x LEN_WIDTH word counts, channel i at slice i
//   in_enq__RDY[i]      channel i holding register empty
//   out_enq__ENA        beat transfer (state active and downstream ready)
//   out_enq_v           beat data
//   out_enq_last        final beat of the current message
//   out_enq__RDY        downstream can accept
//   err                 sticky length-overflow flag
//   busy                serialiser not idle
module noc_funnel_arb #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned HEADER     = 1
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [CHANNELS-1:0]            in_enq__ENA,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_enq_v,
  input  logic [CHANNELS*LEN_WIDTH-1:0]  in_enq_length,
  output logic [CHANNELS-1:0]            in_enq__RDY,
  output logic                           out_enq__ENA,
  output logic [WIDTH-1:0]               out_enq_v,
  output logic                           out_enq_last,
  input  logic                           out_enq__RDY,
  output logic                           err,
  output logic                           busy
);

  localparam int unsigned MAXW = DATA_WIDTH / WIDTH;
  localparam int unsigned CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned NW   = $clog2(MAXW + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                                 r_state;
  logic [CHANNELS-1:0]                    r_valid;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]    r_pay;
  logic [CHANNELS-1:0][LEN_WIDTH-1:0]     r_len;
  logic [CW-1:0]                          r_rr;
  logic [CW-1:0]                          r_ch;
  logic [NW-1:0]                          r_cnt;
  logic [DATA_WIDTH-1:0]                  r_shift;
  logic                                   r_err;

  logic                 w_fire;
  logic                 w_last;
  logic                 w_found;
  logic [CW-1:0]        w_gidx;
  logic [LEN_WIDTH-1:0] w_glen_raw;
  logic                 w_gover;
  logic [NW-1:0]        w_glen;
  logic                 w_grant;
  logic [WIDTH-1:0]     w_hdr;

  // Pick the first valid channel searching upward from r_rr+1, wrapping.
  always_comb begin : p_pick
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      idx = 32'(r_rr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!w_found && r_valid[CW'(idx)]) begin
        w_found = 1'b1;
        w_gidx  = CW'(idx);
      end
    end
  end

  // Length clamp for the candidate message.
  assign w_glen_raw = r_len[w_gidx];
  assign w_gover    = (32'(w_glen_raw) > MAXW);
  assign w_glen     = w_gover ? NW'(MAXW) : NW'(w_glen_raw);

  // r_cnt still holds the clamped length while the header is on the bus.
  always_comb begin
    w_hdr                    = '0;
    w_hdr[LEN_WIDTH-1:0]     = LEN_WIDTH'(r_cnt);
    w_hdr[LEN_WIDTH +: 8]    = 8'(r_ch);
  end

  assign w_last  = ((r_state == S_HEAD) && (r_cnt == '0)) ||
                   ((r_state == S_DATA) && (r_cnt == NW'(1)));
  assign w_fire  = out_enq__ENA;
  // Grant on idle, or on the edge that retires the final beat (no bubble).
  assign w_grant = w_found && ((r_state == S_IDLE) || (w_fire && w_last));

  assign out_enq__ENA = nRST && (r_state != S_IDLE) && out_enq__RDY;
  assign out_enq_v    = (r_state == S_HEAD) ? w_hdr : r_shift[WIDTH-1:0];
  assign out_enq_last = w_last;
  assign in_enq__RDY  = {CHANNELS{nRST}} & ~r_valid;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;

  // Holding register payload/length capture (no reset needed on data).
  always_ff @(posedge CLK) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_enq__ENA[i] && !r_valid[i]) begin
        r_pay[i] <= in_enq_v[i*DATA_WIDTH +: DATA_WIDTH];
        r_len[i] <= in_enq_length[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Valid bits, arbitration pointer and serialiser FSM.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_valid <= '0;
      r_rr    <= CW'(CHANNELS - 1);
      r_ch    <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_err   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (in_enq__ENA[i]) r_valid[i] <= 1'b1;
      end
      if (w_grant) begin
        r_valid[w_gidx] <= 1'b0;
        r_rr            <= w_gidx;
        r_ch            <= w_gidx;
        r_cnt           <= w_glen;
        r_shift         <= r_pay[w_gidx];
        if (w_gover) r_err <= 1'b1;
        if (HEADER != 0)         r_state <= S_HEAD;
        else if (w_glen == '0)   r_state <= S_IDLE;
        else                     r_state <= S_DATA;
      end else if (w_fire) begin
        unique case (r_state)
          S_HEAD: r_state <= w_last ? S_IDLE : S_DATA;
          S_DATA: begin
            r_shift <= r_shift >> WIDTH;
            r_cnt   <= r_cnt - NW'(1);
            if (w_last) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_noc_funnel_arb.sv
// tb_noc_funnel_arb: randomized and directed bench for noc_funnel_arb.
// u_dut (HEADER=1, 2 channels) is checked every cycle against a queue-based
// transaction model. u_dut0 (HEADER=0, 3 channels) gets directed checks.
module tb_noc_funnel_arb;

  localparam int unsigned CH   = 2;
  localparam int unsigned CHZ  = 3;
  localparam int unsigned DW   = 128;
  localparam int unsigned LW   = 16;
  localparam int unsigned W    = 32;
  localparam int unsigned MAXW = DW / W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                nrst;
  logic [CH-1:0]       in_ena;
  logic [CH*DW-1:0]    in_v;
  logic [CH*LW-1:0]    in_len;
  logic [CH-1:0]       in_rdy;
  logic                out_ena, out_last, out_rdy, err, busy;
  logic [W-1:0]        out_v;

  logic [CHZ-1:0]      z_ena;
  logic [CHZ*DW-1:0]   z_v;
  logic [CHZ*LW-1:0]   z_len;
  logic [CHZ-1:0]      z_rdy;
  logic                z_out_ena, z_out_last, z_out_rdy, z_err, z_busy;
  logic [W-1:0]        z_out_v;

  noc_funnel_arb #(.CHANNELS(CH), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .WIDTH(W), .HEADER(1)) u_dut (
    .CLK           (clk),
    .nRST          (nrst),
    .in_enq__ENA   (in_ena),
    .in_enq_v      (in_v),
    .in_enq_length (in_len),
    .in_enq__RDY   (in_rdy),
    .out_enq__ENA  (out_ena),
    .out_enq_v     (out_v),
    .out_enq_last  (out_last),
    .out_enq__RDY  (out_rdy),
    .err           (err),
    .busy          (busy)
  );

  noc_funnel_arb #(.CHANNELS(CHZ), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .WIDTH(W), .HEADER(0)) u_dut0 (
    .CLK           (clk),
    .nRST          (nrst),
    .in_enq__ENA   (z_ena),
    .in_enq_v      (z_v),
    .in_enq_length (z_len),
    .in_enq__RDY   (z_rdy),
    .out_enq__ENA  (z_out_ena),
    .out_enq_v     (z_out_v),
    .out_enq_last  (z_out_last),
    .out_enq__RDY  (z_out_rdy),
    .err           (z_err),
    .busy          (z_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Transaction model: per-channel holding slots, rr pointer, queue of the
  // beats still owed for the message in flight ({last, data}).
  bit           m_hv [CH];
  logic [DW-1:0] m_hp [CH];
  int unsigned  m_hl [CH];
  int unsigned  m_rr;
  logic [W:0]   m_q [$];
  bit           m_err;
  bit           m_live = 1'b0;

  logic [W:0]   obs [$];
  int           ena_cyc [$];
  logic [W:0]   z_obs [$];
  int           busy_cnt;
  int           cyc = 0;

  task automatic model_edge();
    bit          found;
    int unsigned g, n, c;
    logic [W-1:0] hdr;
    if (!nrst) begin
      foreach (m_hv[i]) m_hv[i] = 1'b0;
      m_q.delete();
      m_err  = 1'b0;
      m_rr   = CH - 1;
      m_live = 1'b1;
    end else begin
      if (m_q.size() > 0 && out_rdy) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        found = 1'b0;
        g = 0;
        for (int unsigned k = 1; k <= CH; k++) begin
          c = (m_rr + k) % CH;
          if (!found && m_hv[c]) begin
            found = 1'b1;
            g = c;
          end
        end
        if (found) begin
          n = (m_hl[g] > MAXW) ? MAXW : m_hl[g];
          if (m_hl[g] > MAXW) m_err = 1'b1;
          hdr = W'(n) | (W'(g) << LW);
          m_q.push_back({(n == 0), hdr});
          for (int unsigned w = 0; w < n; w++)
            m_q.push_back({(w == n - 1), m_hp[g][w*W +: W]});
          m_hv[g] = 1'b0;
          m_rr    = g;
        end
      end
      for (int i = 0; i < CH; i++) begin
        if (in_ena[i]) begin
          m_hv[i] = 1'b1;
          m_hp[i] = in_v[i*DW +: DW];
          m_hl[i] = 32'(in_len[i*LW +: LW]);
        end
      end
    end
  endtask

  // One clock cycle: settle, compare against model, log, advance.
  task automatic step();
    logic [CH-1:0] e_rdy;
    #1;
    if (m_live) begin
      for (int i = 0; i < CH; i++) e_rdy[i] = nrst && !m_hv[i];
      chk("in_rdy", 64'(in_rdy), 64'(e_rdy));
      chk("out_ena", 64'(out_ena), 64'(nrst && (m_q.size() > 0) && out_rdy));
      chk("busy", 64'(busy), 64'(m_q.size() > 0));
      chk("err", 64'(err), 64'(m_err));
      if (nrst && m_q.size() > 0) begin
        chk("beat", 64'({out_last, out_v}), 64'(m_q[0]));
      end
    end
    if (out_ena) begin
      obs.push_back({out_last, out_v});
      ena_cyc.push_back(cyc);
    end
    if (busy) busy_cnt++;
    if (z_out_ena) z_obs.push_back({z_out_last, z_out_v});
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    in_ena = '0;
    z_ena  = '0;
  endtask

  function automatic logic [DW-1:0] mkpay(input logic [W-1:0] base);
    logic [DW-1:0] p;
    for (int k = 0; k < MAXW; k++) p[k*W +: W] = base + W'(k);
    return p;
  endfunction

  function automatic logic [DW-1:0] rndpay();
    logic [DW-1:0] p;
    for (int k = 0; k < MAXW; k++) p[k*W +: W] = $urandom;
    return p;
  endfunction

  task automatic load(input int ch, input int unsigned len, input logic [DW-1:0] pay);
    in_ena[ch]          = 1'b1;
    in_v[ch*DW +: DW]   = pay;
    in_len[ch*LW +: LW] = LW'(len);
  endtask

  task automatic zload(input int ch, input int unsigned len, input logic [DW-1:0] pay);
    z_ena[ch]          = 1'b1;
    z_v[ch*DW +: DW]   = pay;
    z_len[ch*LW +: LW] = LW'(len);
  endtask

  task automatic clr_log();
    obs.delete();
    ena_cyc.delete();
    z_obs.delete();
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    clr_log();
  endtask

  int c0;

  initial begin
    nrst = 1'b0; in_ena = '0; in_v = '0; in_len = '0; out_rdy = 1'b1;
    z_ena = '0; z_v = '0; z_len = '0; z_out_rdy = 1'b1;
    busy_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Single message, length 4.
    c0 = cyc;
    load(0, 4, mkpay(32'hA000_0000));
    step();
    repeat (8) step();
    chk("t1_nbeats", 64'(obs.size()), 64'd5);
    if (obs.size() == 5) begin
      chk("t1_hdr", 64'(obs[0]), 64'({1'b0, 32'h0000_0004}));
      for (int k = 0; k < 4; k++)
        chk("t1_word", 64'(obs[k+1]), 64'({(k == 3), 32'hA000_0000 + 32'(k)}));
      chk("t1_latency", 64'(ena_cyc[0] - c0), 64'd2);
    end
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd5);

    // Round-robin, both channels loaded together.
    do_reset();
    load(0, 1, mkpay(32'hB000_0000));
    load(1, 1, mkpay(32'hC000_0000));
    step();
    repeat (8) step();
    chk("t2_nbeats", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) begin
      chk("t2_h0", 64'(obs[0]), 64'({1'b0, 32'h0000_0001}));
      chk("t2_w0", 64'(obs[1]), 64'({1'b1, 32'hB000_0000}));
      chk("t2_h1", 64'(obs[2]), 64'({1'b0, 32'h0001_0001}));
      chk("t2_w1", 64'(obs[3]), 64'({1'b1, 32'hC000_0000}));
      chk("t2_no_bubble", 64'(ena_cyc[3] - ena_cyc[0]), 64'd3);
    end

    // Backpressure mid-message.
    do_reset();
    load(0, 4, mkpay(32'hD000_0000));
    step();
    step();
    out_rdy = 1'b1; step();
    out_rdy = 1'b0; step();
    out_rdy = 1'b0; step();
    out_rdy = 1'b1; step();
    repeat (6) step();
    chk("t3_nbeats", 64'(obs.size()), 64'd5);
    if (obs.size() == 5) begin
      chk("t3_hdr", 64'(obs[0]), 64'({1'b0, 32'h0000_0004}));
      for (int k = 0; k < 4; k++)
        chk("t3_word", 64'(obs[k+1]), 64'({(k == 3), 32'hD000_0000 + 32'(k)}));
    end

    // Length overflow.
    do_reset();
    load(0, 9, mkpay(32'hE000_0000));
    step();
    repeat (8) step();
    chk("t4_nbeats", 64'(obs.size()), 64'd5);
    if (obs.size() == 5) begin
      chk("t4_hdr", 64'(obs[0]), 64'({1'b0, 32'h0000_0004}));
      chk("t4_lastw", 64'(obs[4]), 64'({1'b1, 32'hE000_0003}));
    end
    chk("t4_err", 64'(err), 64'd1);
    repeat (5) step();
    chk("t4_err_sticky", 64'(err), 64'd1);
    do_reset();
    #1;
    chk("t4_err_cleared", 64'(err), 64'd0);

    // Zero length with header.
    load(0, 0, mkpay(32'h1234_0000));
    step();
    repeat (4) step();
    chk("t5_nbeats", 64'(obs.size()), 64'd1);
    if (obs.size() == 1) chk("t5_hdr", 64'(obs[0]), 64'({1'b1, 32'h0000_0000}));

    // Reset mid-message, then priority after release.
    do_reset();
    load(0, 4, mkpay(32'hF000_0000));
    step();
    for (int i = 0; i < 10 && obs.size() < 2; i++) step();
    chk("t6_two_beats", 64'(obs.size()), 64'd2);
    nrst = 1'b0;
    step();
    #1;
    chk("t6_ena_rst", 64'(out_ena), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
    chk("t6_rdy_rst", 64'(in_rdy), 64'd0);
    step();
    nrst = 1'b1;
    clr_log();
    load(1, 1, mkpay(32'h2200_0000));
    load(0, 1, mkpay(32'h1100_0000));
    step();
    repeat (8) step();
    chk("t6_nbeats", 64'(obs.size()), 64'd4);
    if (obs.size() == 4) begin
      chk("t6_first_hdr", 64'(obs[0]), 64'({1'b0, 32'h0000_0001}));
      chk("t6_first_word", 64'(obs[1]), 64'({1'b1, 32'h1100_0000}));
      chk("t6_second_hdr", 64'(obs[2]), 64'({1'b0, 32'h0001_0001}));
    end

    // Randomized traffic with backpressure and occasional resets.
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      nrst    = ($urandom_range(0, 249) != 0);
      out_rdy = ($urandom_range(0, 9) < 7);
      if (nrst) begin
        for (int ch = 0; ch < CH; ch++)
          if (!m_hv[ch] && $urandom_range(0, 2) == 0)
            load(ch, $urandom_range(0, 7), rndpay());
      end
      step();
    end
    nrst = 1'b1;
    out_rdy = 1'b1;
    repeat (20) step();

    // HEADER=0 instance: zero length dropped, then payload-only beats.
    do_reset();
    z_out_rdy = 1'b1;
    zload(2, 0, mkpay(32'h9000_0000));
    step();
    repeat (4) step();
    chk("z_drop_nbeats", 64'(z_obs.size()), 64'd0);
    chk("z_drop_rdy", 64'(z_rdy), 64'b111);
    chk("z_drop_busy", 64'(z_busy), 64'd0);
    zload(0, 2, mkpay(32'h5000_0000));
    zload(1, 3, mkpay(32'h6000_0000));
    step();
    repeat (10) step();
    chk("z_nbeats", 64'(z_obs.size()), 64'd5);
    if (z_obs.size() == 5) begin
      chk("z_b0", 64'(z_obs[0]), 64'({1'b0, 32'h5000_0000}));
      chk("z_b1", 64'(z_obs[1]), 64'({1'b1, 32'h5000_0001}));
      chk("z_b2", 64'(z_obs[2]), 64'({1'b0, 32'h6000_0000}));
      chk("z_b4", 64'(z_obs[4]), 64'({1'b1, 32'h6000_0002}));
    end
    z_obs.delete();
    zload(2, 9, mkpay(32'h7000_0000));
    step();
    repeat (8) step();
    chk("z_ovf_nbeats", 64'(z_obs.size()), 64'd4);
    if (z_obs.size() == 4) chk("z_ovf_last", 64'(z_obs[3]), 64'({1'b1, 32'h7000_0003}));
    chk("z_ovf_err", 64'(z_err), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
